// File: rtl/cpu_control.sv
// -----------------------------------------------------------------------------
// cpu_control
// Sequencing/decode FSM for the 16-bit stack CPU datapath. Steps through
// INIT -> FETCH -> EX1 [-> EX2 [-> EX3]] -> FETCH ... and drives every
// datapath control input. All outputs are decoded from the current state plus
// the opcode already latched in the instruction register.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   opcode       in   cmd[15:10] from the instruction register
//   cmd_w        out  load instruction register from in_data
//   R1_w, R2_w   out  load R1 / R2 from in_data
//   SR_w, PC_w   out  load stack register / program counter
//   SR_inc       out  SR step direction (1 = +1, 0 = -1)
//   PC_inc       out  PC step direction (1 = +1, 0 = -1)
//   SR_incc      out  SR source: 0 ALU_res, 1 SR+-1, 2 0xFFFF, 3 zero
//   PC_incc      out  PC source: 0 ALU_res, 1 PC+-1, 2 0x0020, 3 zero
//   ALU_func     out  ALU function (111 = PASS_R1)
//   addr_sel     out  address source: 0 SR, 1 SR+-1, 2 PC+-1, 3 R1
//   data_sel     out  write data source: 0 SR, 1 PC, 2 ALU_res, 3 cmd[9:0]
//   write_memory out  memory write strobe
//   error        out  sticky illegal-opcode flag
// -----------------------------------------------------------------------------
module cpu_control #(
    parameter int OPW  = 6,
    parameter int ALUW = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OPW-1:0]  opcode,
    output logic            cmd_w,
    output logic            R1_w,
    output logic            R2_w,
    output logic            SR_w,
    output logic            PC_w,
    output logic            SR_inc,
    output logic            PC_inc,
    output logic [1:0]      SR_incc,
    output logic [1:0]      PC_incc,
    output logic [ALUW-1:0] ALU_func,
    output logic [1:0]      addr_sel,
    output logic [1:0]      data_sel,
    output logic            write_memory,
    output logic            error
);

    typedef enum logic [2:0] {
        S_INIT,
        S_FETCH,
        S_EX1,
        S_EX2,
        S_EX3,
        S_HALT,
        S_ERR
    } state_t;

    localparam logic [OPW-1:0]  OP_NOP    = OPW'(8'h00);
    localparam logic [OPW-1:0]  OP_PUSH   = OPW'(8'h01);
    localparam logic [OPW-1:0]  OP_POP    = OPW'(8'h02);
    localparam logic [OPW-1:0]  OP_ALU_LO = OPW'(8'h08);
    localparam logic [OPW-1:0]  OP_ALU_HI = OPW'(8'h0E);
    localparam logic [OPW-1:0]  OP_JMP    = OPW'(8'h10);
    localparam logic [OPW-1:0]  OP_LOAD   = OPW'(8'h11);
    localparam logic [OPW-1:0]  OP_HALT   = OPW'(8'h3F);
    localparam logic [ALUW-1:0] ALU_PASS  = '1;

    state_t state, next_state;
    logic   error_q;
    logic   is_alu;

    assign is_alu = (opcode >= OP_ALU_LO) && (opcode <= OP_ALU_HI);
    assign error  = error_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_INIT;
            error_q <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state == S_ERR)
                error_q <= 1'b1;
        end
    end

    // Outputs are forced low while rst_n is asserted so that an instruction
    // interrupted by reset can never leave a memory write strobe or register
    // load active before the next clock edge (INIT itself drives SR_w/PC_w).
    always_comb begin
        next_state   = state;
        cmd_w        = 1'b0;
        R1_w         = 1'b0;
        R2_w         = 1'b0;
        SR_w         = 1'b0;
        PC_w         = 1'b0;
        SR_inc       = 1'b0;
        PC_inc       = 1'b0;
        SR_incc      = 2'd0;
        PC_incc      = 2'd0;
        ALU_func     = '0;
        addr_sel     = 2'd0;
        data_sel     = 2'd0;
        write_memory = 1'b0;

        if (rst_n) begin
            case (state)
                S_INIT: begin
                    SR_w       = 1'b1;
                    SR_incc    = 2'd2;
                    PC_w       = 1'b1;
                    PC_incc    = 2'd2;
                    next_state = S_FETCH;
                end

                // Fetch from PC+1 while PC itself advances to PC+1.
                S_FETCH: begin
                    addr_sel   = 2'd2;
                    PC_inc     = 1'b1;
                    PC_incc    = 2'd1;
                    PC_w       = 1'b1;
                    cmd_w      = 1'b1;
                    next_state = S_EX1;
                end

                S_EX1: begin
                    if (opcode == OP_NOP) begin
                        next_state = S_FETCH;
                    end else if (opcode == OP_PUSH) begin
                        addr_sel     = 2'd0;
                        SR_incc      = 2'd1;
                        SR_w         = 1'b1;
                        write_memory = 1'b1;
                        data_sel     = 2'd3;
                        next_state   = S_FETCH;
                    end else if (opcode == OP_POP) begin
                        // Discard top of stack: only SR moves.
                        SR_inc     = 1'b1;
                        SR_incc    = 2'd1;
                        SR_w       = 1'b1;
                        next_state = S_FETCH;
                    end else if (is_alu) begin
                        // Top of stack is the right-hand operand.
                        addr_sel   = 2'd1;
                        SR_inc     = 1'b1;
                        SR_incc    = 2'd1;
                        SR_w       = 1'b1;
                        R2_w       = 1'b1;
                        next_state = S_EX2;
                    end else if (opcode == OP_JMP || opcode == OP_LOAD) begin
                        addr_sel   = 2'd1;
                        SR_inc     = 1'b1;
                        SR_incc    = 2'd1;
                        SR_w       = 1'b1;
                        R1_w       = 1'b1;
                        next_state = S_EX2;
                    end else if (opcode == OP_HALT) begin
                        next_state = S_HALT;
                    end else begin
                        next_state = S_ERR;
                    end
                end

                S_EX2: begin
                    if (opcode == OP_JMP) begin
                        // PC <= popped target; the next fetch then reads target+1.
                        ALU_func   = ALU_PASS;
                        PC_incc    = 2'd0;
                        PC_w       = 1'b1;
                        next_state = S_FETCH;
                    end else if (opcode == OP_LOAD) begin
                        // R1 holds the address and is overwritten by mem[R1].
                        addr_sel   = 2'd3;
                        R1_w       = 1'b1;
                        next_state = S_EX3;
                    end else begin
                        addr_sel   = 2'd1;
                        SR_inc     = 1'b1;
                        SR_incc    = 2'd1;
                        SR_w       = 1'b1;
                        R1_w       = 1'b1;
                        next_state = S_EX3;
                    end
                end

                S_EX3: begin
                    addr_sel     = 2'd0;
                    SR_incc      = 2'd1;
                    SR_w         = 1'b1;
                    write_memory = 1'b1;
                    data_sel     = 2'd2;
                    ALU_func     = is_alu ? opcode[ALUW-1:0] : ALU_PASS;
                    next_state   = S_FETCH;
                end

                S_HALT:  next_state = S_HALT;
                S_ERR:   next_state = S_ERR;
                default: next_state = S_INIT;
            endcase
        end
    end

endmodule
